// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between the fetch (IF) and memory-stage (DM)
// requesters. DM has fixed priority, bounded by a starvation guard that forces IF through.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

  logic [1:0]    state;
  logic          owner;
  logic [3:0]    starve_cnt;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;

  logic in_resp;
  logic decide;
  logic if_elig;
  logic dm_elig;
  logic grant;
  logic pick_if;

  // The port being acked in RESP is masked: its requester only drops req next cycle.
  assign in_resp = (state == RESP);
  assign decide  = (state == IDLE) || in_resp;
  assign if_elig = if_req && !(in_resp && owner == OWN_IF);
  assign dm_elig = dm_req && !(in_resp && owner == OWN_DM);
  assign grant   = decide && (if_elig || dm_elig);
  assign pick_if = if_elig && (!dm_elig || starve_cnt == STARVE_LIM);

  assign if_ack = in_resp && (owner == OWN_IF);
  assign dm_ack = in_resp && (owner == OWN_DM);
  assign busy   = (state == GRANT) || (state == RESP);

  // mem_we is held through RESP, so it still tells a load from a store there.
  assign if_rdata = if_ack ? mem_rdata : if_rdata_q;
  assign dm_rdata = (dm_ack && !mem_we) ? mem_rdata : dm_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (!if_req) begin
        starve_cnt <= '0;
      end else if (grant) begin
        if (pick_if)
          starve_cnt <= '0;
        else if (starve_cnt < STARVE_LIM)
          starve_cnt <= starve_cnt + 4'd1;
      end

      if (in_resp) begin
        if (owner == OWN_IF)
          if_rdata_q <= mem_rdata;
        else if (!mem_we)
          dm_rdata_q <= mem_rdata;
      end

      if (grant) begin
        state    <= GRANT;
        owner    <= pick_if ? OWN_IF : OWN_DM;
        mem_en   <= 1'b1;
        mem_we   <= !pick_if && dm_we;
        mem_addr <= pick_if ? if_addr : dm_addr;
        if (!pick_if)
          mem_wdata <= dm_wdata;
      end else if (state == GRANT) begin
        state  <= RESP;
        mem_en <= 1'b0;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule
